// File: rtl/dma_regfile_pkg.sv
// Shared types for the DMA channel register file: control-register codes, mode field layout
// and the channel-index width helper.
package dma_regfile_pkg;

   typedef enum logic [2:0] {
      CMD_STATUS     = 3'b000,
      REQUEST        = 3'b001,
      SINGLE_MASK    = 3'b010,
      MODE_WR        = 3'b011,
      CLEAR_FF       = 3'b100,
      MASTER_CLEAR   = 3'b101,
      CLEAR_MASK     = 3'b110,
      WRITE_ALL_MASK = 3'b111
   } ctl_code_e;

   typedef struct packed {
      logic [1:0] xfer_mode;
      logic       dec;
      logic       autoinit;
      logic [1:0] xfer_type;
   } mode_t;

   localparam int MODE_W            = 6;
   localparam int MODE_TYPE_LSB     = 0;
   localparam int MODE_AUTOINIT_BIT = 2;
   localparam int MODE_DEC_BIT      = 3;
   localparam int MODE_MODE_LSB     = 4;

   function automatic int log2_ceil(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/dma_access_detect.sv
// Qualifies CPU strobes, fires one-cycle action strobes on the first qualified edge, decodes address.
// Combinational outputs from a one-flop edge detector; no backpressure.
module dma_access_detect
   import dma_regfile_pkg::*;
#(
   parameter int AW      = 4,
   parameter int CH_BITS = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               prog_en,
   input  logic               cs_n,
   input  logic               ior_n,
   input  logic               iow_n,
   input  logic [AW-1:0]      addr,
   output logic               ch_wr,
   output logic               ch_rd,
   output logic               ctl_wr,
   output logic               stat_rd,
   output logic               rd_qual,
   output logic [CH_BITS-1:0] ch_sel,
   output logic               cnt_sel,
   output ctl_code_e          ctl_code
);

   logic seen_q, seen_d;
   logic qual, act, is_rd, is_ctl;

   always_comb begin
      qual     = prog_en & ~cs_n & (ior_n ^ iow_n);
      seen_d   = qual;
      act      = qual & ~seen_q;
      is_rd    = ~ior_n;
      is_ctl   = addr[AW-1];
      ch_sel   = addr[CH_BITS:1];
      cnt_sel  = addr[0];
      ctl_code = ctl_code_e'(addr[2:0]);
      ch_wr    = act & ~is_ctl & ~is_rd;
      ch_rd    = act & ~is_ctl & is_rd;
      ctl_wr   = act & is_ctl & ~is_rd;
      stat_rd  = act & is_ctl & is_rd & (addr[2:0] == CMD_STATUS);
      rd_qual  = qual & is_rd;
   end

   // Resets to "seen" so a strobe still low after reset release must go high before it acts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) seen_q <= 1'b1;
      else        seen_q <= seen_d;
   end

endmodule

// File: rtl/dma_channel_regfile.sv
// DMA programming register file: N channels, byte-sequenced CPU access, status clear-on-read, engine writeback.
// Writes visible next cycle, reads 1 cycle; no backpressure. Option DMA_AUTOINIT_EN enables tc reload.
module dma_channel_regfile
   import dma_regfile_pkg::*;
#(
   parameter  int NUM_CHANNELS = 4,
   parameter  int DATA_WIDTH   = 8,
   localparam int REG_WIDTH    = 2 * DATA_WIDTH,
   localparam int CH_BITS      = log2_ceil(NUM_CHANNELS),
   localparam int AW           = CH_BITS + 2
) (
   input  logic                              CLK,
   input  logic                              RESET_N,
   input  logic                              programCondition,
   input  logic                              CS_N,
   input  logic                              IOR_N,
   input  logic                              IOW_N,
   input  logic [AW-1:0]                     A,
   input  logic [DATA_WIDTH-1:0]             DB_IN,
   output logic [DATA_WIDTH-1:0]             DB_OUT,
   output logic                              DB_OE,
   input  logic [NUM_CHANNELS-1:0]           reqIn,
   input  logic [NUM_CHANNELS-1:0]           tcIn,
   input  logic                              updEn,
   input  logic [CH_BITS-1:0]                updCh,
   input  logic [REG_WIDTH-1:0]              updAddr,
   input  logic [REG_WIDTH-1:0]              updCount,
   output logic [DATA_WIDTH-1:0]             command,
   output logic [NUM_CHANNELS*MODE_W-1:0]    mode,
   output logic [NUM_CHANNELS-1:0]           mask,
   output logic [NUM_CHANNELS-1:0]           swReq,
   output logic [NUM_CHANNELS*REG_WIDTH-1:0] curAddr,
   output logic [NUM_CHANNELS*REG_WIDTH-1:0] curCount
);

   if (NUM_CHANNELS < 4 || (NUM_CHANNELS & (NUM_CHANNELS - 1)) != 0 ||
       DATA_WIDTH < 2 * NUM_CHANNELS || DATA_WIDTH < CH_BITS + 6) begin : g_bad_cfg
      $error("dma_channel_regfile: unsupported NUM_CHANNELS/DATA_WIDTH combination");
   end

   logic               ch_wr, ch_rd, ctl_wr, stat_rd, rd_qual, cnt_sel;
   logic [CH_BITS-1:0] ch_sel;
   ctl_code_e          ctl_code;

   logic [REG_WIDTH-1:0]    base_addr_q [NUM_CHANNELS], base_addr_d [NUM_CHANNELS];
   logic [REG_WIDTH-1:0]    base_cnt_q  [NUM_CHANNELS], base_cnt_d  [NUM_CHANNELS];
   logic [REG_WIDTH-1:0]    cur_addr_q  [NUM_CHANNELS], cur_addr_d  [NUM_CHANNELS];
   logic [REG_WIDTH-1:0]    cur_cnt_q   [NUM_CHANNELS], cur_cnt_d   [NUM_CHANNELS];
   mode_t                   mode_q      [NUM_CHANNELS], mode_d      [NUM_CHANNELS];
   logic [DATA_WIDTH-1:0]   command_q, command_d, db_out_q, db_out_d;
   logic                    db_oe_q, db_oe_d, ff_q, ff_d;
   logic [NUM_CHANNELS-1:0] mask_q, mask_d, swreq_q, swreq_d, tc_q, tc_d, reload;
   logic [REG_WIDTH-1:0]    rd_reg, wr_cur, wr_base;
   logic [DATA_WIDTH-1:0]   rd_data;
   logic [CH_BITS-1:0]      db_ch;

   dma_access_detect #(.AW(AW), .CH_BITS(CH_BITS)) u_detect (
      .clk      (CLK),
      .rst_n    (RESET_N),
      .prog_en  (programCondition),
      .cs_n     (CS_N),
      .ior_n    (IOR_N),
      .iow_n    (IOW_N),
      .addr     (A),
      .ch_wr    (ch_wr),
      .ch_rd    (ch_rd),
      .ctl_wr   (ctl_wr),
      .stat_rd  (stat_rd),
      .rd_qual  (rd_qual),
      .ch_sel   (ch_sel),
      .cnt_sel  (cnt_sel),
      .ctl_code (ctl_code)
   );

   always_comb begin
      reload = '0;
`ifdef DMA_AUTOINIT_EN
      for (int i = 0; i < NUM_CHANNELS; i++) reload[i] = tcIn[i] & mode_q[i].autoinit;
`endif
   end

   always_comb begin
      base_addr_d = base_addr_q;
      base_cnt_d  = base_cnt_q;
      cur_addr_d  = cur_addr_q;
      cur_cnt_d   = cur_cnt_q;
      mode_d      = mode_q;
      command_d   = command_q;
      mask_d      = mask_q;
      swreq_d     = swreq_q;
      ff_d        = ff_q;
      db_ch       = DB_IN[CH_BITS-1:0];
      tc_d        = stat_rd ? tcIn : (tc_q | tcIn);
      wr_cur      = '0;
      wr_base     = '0;

      rd_reg  = cnt_sel ? cur_cnt_q[ch_sel] : cur_addr_q[ch_sel];
      rd_data = '0;
      if (ch_rd)        rd_data = ff_q ? rd_reg[REG_WIDTH-1 -: DATA_WIDTH] : rd_reg[DATA_WIDTH-1:0];
      else if (stat_rd) rd_data[2*NUM_CHANNELS-1:0] = {reqIn, tc_q};
      db_oe_d  = ch_rd | stat_rd | (db_oe_q & rd_qual);
      db_out_d = (ch_rd | stat_rd) ? rd_data : ((db_oe_q & rd_qual) ? db_out_q : '0);

      if (updEn) begin
         cur_addr_d[updCh] = updAddr;
         cur_cnt_d[updCh]  = updCount;
      end

      // CPU byte is merged into the pre-update value, so a coincident engine write is dropped.
      if (ch_wr) begin
         ff_d    = ~ff_q;
         wr_cur  = cnt_sel ? cur_cnt_q[ch_sel]  : cur_addr_q[ch_sel];
         wr_base = cnt_sel ? base_cnt_q[ch_sel] : base_addr_q[ch_sel];
         if (ff_q) begin
            wr_cur[REG_WIDTH-1 -: DATA_WIDTH]  = DB_IN;
            wr_base[REG_WIDTH-1 -: DATA_WIDTH] = DB_IN;
         end else begin
            wr_cur[DATA_WIDTH-1:0]  = DB_IN;
            wr_base[DATA_WIDTH-1:0] = DB_IN;
         end
         if (cnt_sel) begin
            cur_cnt_d[ch_sel]  = wr_cur;
            base_cnt_d[ch_sel] = wr_base;
         end else begin
            cur_addr_d[ch_sel]  = wr_cur;
            base_addr_d[ch_sel] = wr_base;
         end
      end
      if (ch_rd) ff_d = ~ff_q;

      if (ctl_wr) begin
         case (ctl_code)
            CMD_STATUS:     command_d = DB_IN;
            REQUEST:        swreq_d[db_ch] = DB_IN[CH_BITS];
            SINGLE_MASK:    mask_d[db_ch] = DB_IN[CH_BITS];
            MODE_WR:        mode_d[db_ch] = mode_t'(DB_IN[DATA_WIDTH-1 -: MODE_W]);
            CLEAR_FF:       ff_d = 1'b0;
            CLEAR_MASK:     mask_d = '0;
            WRITE_ALL_MASK: mask_d = DB_IN[NUM_CHANNELS-1:0];
            default:        ;
         endcase
      end

      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (tcIn[i] && !reload[i]) mask_d[i] = 1'b1;
         if (reload[i]) begin
            cur_addr_d[i] = base_addr_q[i];
            cur_cnt_d[i]  = base_cnt_q[i];
         end
      end

      if (ctl_wr && ctl_code == MASTER_CLEAR) begin
         command_d = '0;
         mask_d    = '1;
         swreq_d   = '0;
         tc_d      = '0;
         ff_d      = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            base_addr_q[i] <= '0;
            base_cnt_q[i]  <= '0;
            cur_addr_q[i]  <= '0;
            cur_cnt_q[i]   <= '0;
            mode_q[i]      <= '0;
         end
         command_q <= '0;
         db_out_q  <= '0;
         db_oe_q   <= 1'b0;
         ff_q      <= 1'b0;
         mask_q    <= '1;
         swreq_q   <= '0;
         tc_q      <= '0;
      end else begin
         base_addr_q <= base_addr_d;
         base_cnt_q  <= base_cnt_d;
         cur_addr_q  <= cur_addr_d;
         cur_cnt_q   <= cur_cnt_d;
         mode_q      <= mode_d;
         command_q   <= command_d;
         db_out_q    <= db_out_d;
         db_oe_q     <= db_oe_d;
         ff_q        <= ff_d;
         mask_q      <= mask_d;
         swreq_q     <= swreq_d;
         tc_q        <= tc_d;
      end
   end

   always_comb begin
      DB_OUT  = db_out_q;
      DB_OE   = db_oe_q;
      command = command_q;
      mask    = mask_q;
      swReq   = swreq_q;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         mode[i*MODE_W +: MODE_W]        = mode_q[i];
         curAddr[i*REG_WIDTH +: REG_WIDTH]  = cur_addr_q[i];
         curCount[i*REG_WIDTH +: REG_WIDTH] = cur_cnt_q[i];
      end
   end

endmodule

// File: tb/tb_dma_channel_regfile.sv
// Directed bench for dma_channel_regfile (4 channels, 8-bit data): vector table plus corner sequences.
module tb_dma_channel_regfile;

   logic        CLK = 1'b0;
   logic        RESET_N, programCondition, CS_N, IOR_N, IOW_N, DB_OE, updEn;
   logic [3:0]  A, reqIn, tcIn, mask, swReq;
   logic [7:0]  DB_IN, DB_OUT, command;
   logic [1:0]  updCh;
   logic [15:0] updAddr, updCount;
   logic [23:0] mode;
   logic [63:0] curAddr, curCount;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   dma_channel_regfile dut (
      .CLK(CLK), .RESET_N(RESET_N), .programCondition(programCondition),
      .CS_N(CS_N), .IOR_N(IOR_N), .IOW_N(IOW_N), .A(A), .DB_IN(DB_IN),
      .DB_OUT(DB_OUT), .DB_OE(DB_OE), .reqIn(reqIn), .tcIn(tcIn),
      .updEn(updEn), .updCh(updCh), .updAddr(updAddr), .updCount(updCount),
      .command(command), .mode(mode), .mask(mask), .swReq(swReq),
      .curAddr(curAddr), .curCount(curCount)
   );

   typedef enum int {OP_WR, OP_RD, OP_IDLE} op_e;
   typedef enum int {K_DB, K_CMD, K_MASK, K_SWREQ, K_MODE, K_ADDR, K_CNT} kind_e;
   typedef struct {
      op_e         op;
      logic [3:0]  a;
      logic [7:0]  din;
      kind_e       kind;
      logic [63:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] obs(input kind_e k);
      case (k)
         K_DB:    return {56'd0, DB_OUT};
         K_CMD:   return {56'd0, command};
         K_MASK:  return {60'd0, mask};
         K_SWREQ: return {60'd0, swReq};
         K_MODE:  return {40'd0, mode};
         K_ADDR:  return curAddr;
         default: return curCount;
      endcase
   endfunction

   task automatic add(input op_e op, input logic [3:0] a, input logic [7:0] din,
                      input kind_e k, input logic [63:0] exp, input string name);
      vec_t v;
      v.op = op; v.a = a; v.din = din; v.kind = k; v.exp = exp; v.name = name;
      vecs.push_back(v);
   endtask

   // Drives one strobe pulse held for 'hold' clock edges; dout is sampled after the last held edge.
   task automatic access(input bit rd, input logic [3:0] a, input logic [7:0] din,
                         input int hold, output logic [7:0] dout);
      @(negedge CLK);
      CS_N = 1'b0; A = a; DB_IN = din; IOR_N = ~rd; IOW_N = rd;
      repeat (hold) @(negedge CLK);
      dout = DB_OUT;
      CS_N = 1'b1; IOR_N = 1'b1; IOW_N = 1'b1;
      @(negedge CLK);
   endtask

   logic [7:0] d;

   initial begin
      RESET_N = 1'b0; programCondition = 1'b1; CS_N = 1'b1; IOR_N = 1'b1; IOW_N = 1'b1;
      A = '0; DB_IN = '0; reqIn = '0; tcIn = '0; updEn = 1'b0; updCh = '0;
      updAddr = '0; updCount = '0;

      add(OP_WR,   4'h4, 8'h34, K_ADDR,  64'h0000_0034_0000_0000, "ch2 addr low");
      add(OP_WR,   4'h4, 8'h12, K_ADDR,  64'h0000_1234_0000_0000, "ch2 addr high");
      add(OP_RD,   4'h4, 8'h00, K_DB,    64'h34, "ch2 read low");
      add(OP_RD,   4'h4, 8'h00, K_DB,    64'h12, "ch2 read high");
      add(OP_WR,   4'h8, 8'hA5, K_CMD,   64'hA5, "command write");
      add(OP_WR,   4'hA, 8'h01, K_MASK,  64'hD, "single mask clear ch1");
      add(OP_WR,   4'hA, 8'h05, K_MASK,  64'hF, "single mask set ch1");
      add(OP_WR,   4'hF, 8'h06, K_MASK,  64'h6, "write all masks");
      add(OP_WR,   4'hE, 8'h00, K_MASK,  64'h0, "clear all masks");
      add(OP_WR,   4'h9, 8'h06, K_SWREQ, 64'h4, "request set ch2");
      add(OP_WR,   4'hB, 8'h13, K_MODE,  64'h10_0000, "mode ch3 autoinit");
      add(OP_RD,   4'h9, 8'h00, K_DB,    64'h0, "read write-only reg");
      add(OP_RD,   4'h8, 8'h00, K_DB,    64'h0, "status idle");
      add(OP_WR,   4'h2, 8'h77, K_ADDR,  64'h0000_1234_0077_0000, "ch1 addr low");
      add(OP_WR,   4'hD, 8'h00, K_MASK,  64'hF, "master clear mask");
      add(OP_IDLE, 4'h0, 8'h00, K_CMD,   64'h0, "master clear command");
      add(OP_IDLE, 4'h0, 8'h00, K_SWREQ, 64'h0, "master clear request");
      add(OP_IDLE, 4'h0, 8'h00, K_MODE,  64'h10_0000, "master clear keeps mode");
      add(OP_RD,   4'h2, 8'h00, K_DB,    64'h77, "master clear resets FF");
      add(OP_RD,   4'h5, 8'h00, K_DB,    64'h0, "ch2 count high");
      add(OP_WR,   4'h5, 8'h9C, K_CNT,   64'h0000_009C_0000_0000, "ch2 count low");

      repeat (2) @(negedge CLK);
      chk("reset DB_OUT", {56'd0, DB_OUT}, 64'h0);
      chk("reset DB_OE", {63'd0, DB_OE}, 64'h0);
      chk("reset mask", {60'd0, mask}, 64'hF);
      chk("reset command", {56'd0, command}, 64'h0);
      chk("reset curAddr", curAddr, 64'h0);
      RESET_N = 1'b1;
      repeat (2) @(negedge CLK);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].op == OP_IDLE) @(negedge CLK);
         else access(vecs[i].op == OP_RD, vecs[i].a, vecs[i].din, 1, d);
         chk(vecs[i].name, (vecs[i].op == OP_RD) ? {56'd0, d} : obs(vecs[i].kind), vecs[i].exp);
      end

      // Held write strobe acts once
      access(1'b0, 4'hC, 8'h00, 1, d);
      access(1'b0, 4'h3, 8'hAA, 5, d);
      chk("held write single action", curCount, 64'h0000_009C_00AA_0000);
      access(1'b0, 4'h3, 8'hBB, 1, d);
      chk("held write left FF=1", curCount, 64'h0000_009C_BBAA_0000);

      // Clear FF between bytes
      access(1'b0, 4'h6, 8'h11, 1, d);
      access(1'b0, 4'hC, 8'h00, 1, d);
      access(1'b0, 4'h6, 8'h22, 1, d);
      chk("clear FF between bytes", curAddr, 64'h0022_1234_0077_0000);

      // Terminal count with ch3 autoinit mode
      access(1'b0, 4'hC, 8'h00, 1, d);
      access(1'b0, 4'h6, 8'h00, 1, d);
      access(1'b0, 4'h6, 8'h01, 1, d);
      access(1'b0, 4'hE, 8'h00, 1, d);
      chk("ch3 base write", {48'd0, curAddr[63:48]}, 64'h0100);
      @(negedge CLK);
      updEn = 1'b1; updCh = 2'd3; updAddr = 16'h0180; updCount = 16'h0005;
      @(negedge CLK);
      updEn = 1'b0;
      chk("engine update ch3", {48'd0, curAddr[63:48]}, 64'h0180);
      tcIn = 4'h8;
      @(negedge CLK);
      tcIn = 4'h0;
`ifdef DMA_AUTOINIT_EN
      chk("tc3 autoinit addr", {48'd0, curAddr[63:48]}, 64'h0100);
      chk("tc3 autoinit count", {48'd0, curCount[63:48]}, 64'h0000);
      chk("tc3 autoinit mask", {60'd0, mask}, 64'h0);
`else
      chk("tc3 addr retained", {48'd0, curAddr[63:48]}, 64'h0180);
      chk("tc3 count retained", {48'd0, curCount[63:48]}, 64'h0005);
      chk("tc3 sets mask", {60'd0, mask}, 64'h8);
`endif

      // Status latching and clear-on-read
      access(1'b1, 4'h8, 8'h00, 1, d);
      chk("status tc3", {56'd0, d}, 64'h08);
      tcIn = 4'h1;
      @(negedge CLK);
      tcIn = 4'h0;
`ifdef DMA_AUTOINIT_EN
      chk("tc0 sets mask", {60'd0, mask}, 64'h1);
`else
      chk("tc0 sets mask", {60'd0, mask}, 64'h9);
`endif
      reqIn = 4'h2;
      access(1'b1, 4'h8, 8'h00, 1, d);
      chk("status read 1", {56'd0, d}, 64'h21);
      @(negedge CLK);
      CS_N = 1'b0; A = 4'h8; IOR_N = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         chk("held read DB_OE", {63'd0, DB_OE}, 64'h1);
         chk("held read DB_OUT", {56'd0, DB_OUT}, 64'h20);
      end
      CS_N = 1'b1; IOR_N = 1'b1;
      @(negedge CLK);
      chk("DB_OE drops after read", {63'd0, DB_OE}, 64'h0);
      @(negedge CLK);
      CS_N = 1'b0; A = 4'h8; IOR_N = 1'b0; tcIn = 4'h2;
      @(negedge CLK);
      tcIn = 4'h0;
      chk("status with new tc", {56'd0, DB_OUT}, 64'h20);
      CS_N = 1'b1; IOR_N = 1'b1;
      @(negedge CLK);
      access(1'b1, 4'h8, 8'h00, 1, d);
      chk("coincident tc kept", {56'd0, d}, 64'h22);
      reqIn = 4'h0;

      // CPU write wins over engine update on the same register
      access(1'b0, 4'hC, 8'h00, 1, d);
      @(negedge CLK);
      CS_N = 1'b0; A = 4'h0; DB_IN = 8'h55; IOW_N = 1'b0;
      updEn = 1'b1; updCh = 2'd0; updAddr = 16'hBEEF; updCount = 16'h1234;
      @(negedge CLK);
      updEn = 1'b0; CS_N = 1'b1; IOW_N = 1'b1;
      chk("cpu beats engine addr", {48'd0, curAddr[15:0]}, 64'h0055);
      chk("engine count ch0", {48'd0, curCount[15:0]}, 64'h1234);

      // Accesses outside program mode are ignored
      programCondition = 1'b0;
      access(1'b0, 4'h8, 8'hFF, 1, d);
      chk("no program mode", {56'd0, command}, 64'h0);
      programCondition = 1'b1;

      // Reset in the middle of a write pulse
      @(negedge CLK);
      CS_N = 1'b0; A = 4'h8; DB_IN = 8'h3C; IOW_N = 1'b0;
      #2 RESET_N = 1'b0;
      repeat (2) @(negedge CLK);
      RESET_N = 1'b1;
      repeat (3) @(negedge CLK);
      chk("reset aborts pulse", {56'd0, command}, 64'h0);
      chk("reset mid-pulse mask", {60'd0, mask}, 64'hF);
      CS_N = 1'b1; IOW_N = 1'b1;
      @(negedge CLK);
      access(1'b0, 4'h8, 8'h3C, 1, d);
      chk("new pulse after reset", {56'd0, command}, 64'h3C);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dma_channel_regfile.md
# dma_channel_regfile

Parametrised programming-side register file for the DMA controller: decodes CPU I/O cycles, holds per-channel base/current address and word-count registers, the command, mode, mask, request and status registers, and the byte-pointer flip-flop. It sits between the CPU bus interface and the transfer engine. It generalises the fixed 4-channel register decode to N channels with configurable widths, and adds real register storage, edge-qualified accesses, two-byte sequencing, status clear-on-read and engine-side update/auto-initialise.

## Interface
- NUM_CHANNELS, 4, channel count; power of two, ≥4.
- DATA_WIDTH, 8, CPU data bus width; must be ≥2·NUM_CHANNELS and ≥CH_BITS+6, else elaboration error.
- REG_WIDTH, 2·DATA_WIDTH (derived), address/count register width.
- CH_BITS = log2(NUM_CHANNELS) and AW = CH_BITS+2 (derived).
- CLK  in  1  single clock.
- RESET_N  in  1  asynchronous, active-low reset.
- programCondition  in  1  program mode; all accesses are ignored when 0.
- CS_N, IOR_N, IOW_N  in  1 each  chip select, read strobe, write strobe (active-low).
- A  in  AW  register address.
- DB_IN  in  DATA_WIDTH  write data.
- DB_OUT  out  DATA_WIDTH  registered read data.
- DB_OE  out  1  read-data enable.
- reqIn  in  NUM_CHANNELS  live DREQ levels, reported in status.
- tcIn  in  NUM_CHANNELS  terminal-count pulse per channel from the engine.
- updEn  in  1; updCh  in  CH_BITS; updAddr, updCount  in  REG_WIDTH each: engine writeback of the current registers.
- command  out  DATA_WIDTH; mode  out  NUM_CHANNELS×6; mask, swReq  out  NUM_CHANNELS each; curAddr, curCount  out  NUM_CHANNELS×REG_WIDTH each.

## Operation
- Address map:
  - A[AW-1]=0 selects channel registers: A[CH_BITS:1] is the channel; A[0]=0 selects address, 1 selects count.
  - A[AW-1]=1 selects control registers by A[2:0]: 000 command write / status read; 001 request; 010 single mask; 011 mode; 100 clear byte-pointer FF; 101 master clear; 110 clear all masks; 111 write all masks.
- An access is qualified when programCondition, !CS_N, and exactly one of IOR_N/IOW_N is low. Control writes outside the listed codes and reads of write-only registers are ignored; DB_OUT is then 0.
- Each strobe pulse produces exactly one action, on the first CLK edge where the qualified access is seen after a cycle in which it was not. Holding a strobe low repeats nothing.
- Channel write: FF=0 writes the low byte, FF=1 the high byte, of both the base and current register; FF toggles.
- Channel read: DB_OUT takes the FF-selected byte of the current register; FF toggles.
- Single-mask and request writes: DB_IN[CH_BITS] is the set/clear value; DB_IN[CH_BITS-1:0] selects the channel.
- Mode write: DB_IN[CH_BITS-1:0] selects the channel; DB_IN[DATA_WIDTH-1 -: 6] is stored as {mode[1:0], dec, autoinit, type[1:0]}.
- Write all masks: mask ← DB_IN[NUM_CHANNELS-1:0].
- Status read: DB_OUT = {reqIn, tcLatched}, zero-extended. The same edge clears tcLatched.
- Master clear: same effect as reset, except base/current/mode registers are retained.
- Engine update: with updEn set, current[updCh] ← updAddr/updCount.
- tcIn[i] sets tcLatched[i] and sets mask[i] unless autoinit is on.

## Timing
- Reset values: DB_OUT=0, DB_OE=0, command=0, mode=0, mask=all 1, swReq=0, tcLatched=0, FF=0, all base/current registers=0.
- Write latency: a register updated on the action edge is visible on its outputs in the next cycle.
- Read latency: DB_OUT/DB_OE are valid 1 cycle after the action edge. DB_OE stays 1 while the read stays qualified, with DB_OUT held; it returns to 0 one cycle after qualification ends.
- Simultaneous events:
  - CPU write and updEn to the same channel register: CPU byte wins, engine bytes are dropped.
  - Status read and a new tcIn on the same bit: bit ends set.
  - Clear-FF and a channel access cannot coincide, since there is one strobe.
- Reset asserted mid-pulse aborts the access. After release, a still-low strobe is not actioned until it deasserts and reasserts.

## Configuration
- DMA_AUTOINIT_EN defined: tcIn[i] with mode autoinit=1 reloads current from base on the same edge and leaves mask[i] unchanged. This overrides a coincident updEn to channel i.
- Not defined: the autoinit bit is stored and readable on mode, but tcIn never reloads, and it always sets mask[i].

## Structure
- Package dma_regfile_pkg holds:
  - the control-code enum (CMD_STATUS … WRITE_ALL_MASK);
  - the mode field struct and mode-bit constants;
  - the width derivation function.
- Sub-module dma_access_detect: qualification, strobe edge detection and address decode, producing one-cycle action strobes.

## Test plan
- Reset, then write 0x34 then 0x12 to channel 2 address (A=0x4): curAddr[2]=0x1234; a read pair returns 0x34 then 0x12.
- Hold IOW_N low for 5 cycles writing count ch1 (A=0x3, 0xAA): exactly one low-byte write, FF=1 after.
- Clear-FF (A=0xC) between bytes: the next write lands in the low byte again.
- tcIn[0] pulse, then status read with reqIn=0x2: DB_OUT=0x21; a second status read gives 0x20.
- DMA_AUTOINIT_EN, ch3 mode autoinit=1, base=0x0100, updEn sets current 0x0180, then tcIn[3]: curAddr[3]=0x0100 next cycle, mask[3]=0. Without the macro: 0x0180 retained, mask[3]=1.
- CPU write and updEn to ch0 address in the same cycle with FF=0, CPU data 0x55, updAddr 0xBEEF: curAddr[0]=0x0055, since the low byte comes from the CPU and the engine bytes are dropped.
